// File: rtl/qm_regfile_sb.sv
// Decode-stage register file: NREAD combinational read ports, one clocked write port with
// write-through bypass, and a per-register load-pending scoreboard. Register 0 reads as zero.
module qm_regfile_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned NREAD      = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NREAD*ADDR_WIDTH-1:0] ra,
    output logic [NREAD*DATA_WIDTH-1:0] rd,
    output logic [NREAD-1:0]            rd_pending,
    input  logic                        we,
    input  logic [ADDR_WIDTH-1:0]       wa,
    input  logic [DATA_WIDTH-1:0]       wd,
    input  logic                        pend_set,
    input  logic [ADDR_WIDTH-1:0]       pend_addr,
    output logic                        any_pending
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      pend_q;
    logic [DEPTH-1:0]      pend_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            rf_q[wa] <= wd;
        end
    end

    // A load issued to the register being written supersedes the write's clear.
    always_comb begin
        pend_d = pend_q;
        if (we) begin
            pend_d[wa] = 1'b0;
        end
        if (pend_set) begin
            pend_d[pend_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign any_pending = |pend_q;

    for (genvar p = 0; p < NREAD; p++) begin : g_rport
        logic [ADDR_WIDTH-1:0] ra_p;
        logic                  hit;
        logic                  clr_ovr;

        assign ra_p    = ra[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit     = we && (wa == ra_p);
        assign clr_ovr = pend_set && (pend_addr == ra_p);

        always_comb begin
            rd[p*DATA_WIDTH +: DATA_WIDTH] = '0;
            rd_pending[p]                  = 1'b0;
            if (ra_p != '0) begin
                rd[p*DATA_WIDTH +: DATA_WIDTH] = hit ? wd : rf_q[ra_p];
                // Bypassed data is valid, so a same-cycle write hides the pending flag.
                rd_pending[p] = pend_q[ra_p] && !(hit && !clr_ovr);
            end
        end
    end

endmodule

// File: tb/tb_qm_regfile_sb.sv
// Scoreboard bench for qm_regfile_sb: default build plus a 4-port 64-bit build,
// with directed cases and a randomised phase checked against a behavioural model.
module tb_qm_regfile_sb;

    logic        clk;
    logic        reset_n;
    logic [4:0]  ra0, ra1;
    logic [63:0] rd;
    logic [1:0]  rd_pending;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        pend_set;
    logic [4:0]  pend_addr;
    logic        any_pending;

    logic [19:0]  w_ra;
    logic [255:0] w_rd;
    logic [3:0]   w_pend;
    logic         w_we;
    logic [4:0]   w_wa;
    logic [63:0]  w_wd;
    logic         w_ps;
    logic [4:0]   w_pa;
    logic         w_any;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic        p0;
        logic        p1;
        logic        any;
    } exp_t;

    exp_t q[$];

    logic [31:0] rf_m [32];
    logic [31:0] pend_m;

    qm_regfile_sb u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ra         ({ra1, ra0}),
        .rd         (rd),
        .rd_pending (rd_pending),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .pend_set   (pend_set),
        .pend_addr  (pend_addr),
        .any_pending(any_pending)
    );

    qm_regfile_sb #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .NREAD     (4)
    ) u_wide (
        .clk        (clk),
        .reset_n    (reset_n),
        .ra         (w_ra),
        .rd         (w_rd),
        .rd_pending (w_pend),
        .we         (w_we),
        .wa         (w_wa),
        .wd         (w_wd),
        .pend_set   (w_ps),
        .pend_addr  (w_pa),
        .any_pending(w_any)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (q.size() == 0) begin
            check("queue_empty", 64'd1, 64'd0);
            return;
        end
        e = q.pop_front();
        check({e.tag, ".rd0"}, {32'd0, rd[31:0]}, {32'd0, e.rd0});
        check({e.tag, ".rd1"}, {32'd0, rd[63:32]}, {32'd0, e.rd1});
        check({e.tag, ".p0"}, {63'd0, rd_pending[0]}, {63'd0, e.p0});
        check({e.tag, ".p1"}, {63'd0, rd_pending[1]}, {63'd0, e.p1});
        check({e.tag, ".any"}, {63'd0, any_pending}, {63'd0, e.any});
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) rf_m[i] = '0;
        pend_m = '0;
    endtask

    task automatic model_upd();
        if (we && wa != 0) rf_m[wa] = wd;
        if (we) pend_m[wa] = 1'b0;
        if (pend_set) pend_m[pend_addr] = 1'b1;
        pend_m[0] = 1'b0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return '0;
        if (we && wa == a) return wd;
        return rf_m[a];
    endfunction

    function automatic logic exp_p(input logic [4:0] a);
        if (a == 0) return 1'b0;
        return pend_m[a] && !(we && wa == a && !(pend_set && pend_addr == a));
    endfunction

    task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic w,
                         input logic [4:0] a, input logic [31:0] d, input logic ps,
                         input logic [4:0] pa);
        ra0 = a0; ra1 = a1; we = w; wa = a; wd = d; pend_set = ps; pend_addr = pa;
    endtask

    // Expectation is queued at drive time and compared at the following falling edge.
    task automatic cyc(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                       input logic ep0, input logic ep1, input logic eany);
        q.push_back('{tag, e0, e1, ep0, ep1, eany});
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        model_upd();
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        w_ra = '0; w_we = 0; w_wa = 0; w_wd = 0; w_ps = 0; w_pa = 0;
        model_clear();
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int a = 0; a < 32; a++) begin
            drive(5'(a), 5'(31 - a), 0, 0, 0, 0, 0);
            cyc("reset_read", 0, 0, 0, 0, 0);
        end

        drive(5, 0, 1, 5, 32'hDEADBEEF, 0, 0);
        cyc("bypass", 32'hDEADBEEF, 0, 0, 0, 0);
        drive(5, 5, 0, 0, 0, 0, 0);
        cyc("after_write", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);

        drive(0, 0, 1, 0, 32'h12345678, 1, 0);
        cyc("r0_write", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc("r0_after", 0, 0, 0, 0, 0);

        drive(0, 7, 0, 0, 0, 1, 7);
        cyc("pend_issue", 0, 0, 0, 0, 0);
        drive(0, 7, 0, 0, 0, 0, 0);
        cyc("pend_seen", 0, 0, 0, 1, 1);
        drive(0, 7, 1, 7, 32'hA5, 0, 0);
        cyc("pend_clear", 0, 32'hA5, 0, 0, 1);
        drive(0, 7, 0, 0, 0, 0, 0);
        cyc("pend_gone", 0, 32'hA5, 0, 0, 0);

        drive(9, 0, 1, 9, 32'h55, 1, 9);
        cyc("set_wr_same", 32'h55, 0, 0, 0, 0);
        drive(9, 9, 0, 0, 0, 0, 0);
        cyc("set_wins", 32'h55, 32'h55, 1, 1, 1);
        drive(9, 0, 1, 9, 32'h66, 1, 9);
        cyc("clear_ovr", 32'h66, 0, 1, 0, 1);
        drive(9, 0, 1, 9, 32'h77, 1, 4);
        cyc("set_other", 32'h77, 0, 0, 0, 1);
        drive(9, 4, 0, 0, 0, 0, 0);
        cyc("both_effect", 32'h77, 0, 0, 1, 1);
        drive(4, 0, 1, 4, 32'h1, 0, 0);
        cyc("clear4", 32'h1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        cyc("all_clear", 0, 0, 0, 0, 0);

        for (int n = 0; n < 300; n++) begin
            drive(5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) ra0 = wa;
            cyc("rnd", exp_rd(ra0), exp_rd(ra1), exp_p(ra0), exp_p(ra1), |pend_m);
        end

        drive(3, 0, 1, 3, 32'hFF, 1, 4);
        w_ra = {4{5'd3}}; w_we = 1; w_wa = 3; w_wd = 64'hFF00_0000_0000_00FF;
        cyc("wr3", 32'hFF, 0, 0, 0, |pend_m);
        for (int p = 0; p < 4; p++) check("wide_bypass", w_rd[p*64 +: 64], 64'hFF00_0000_0000_00FF);
        w_we = 0;
        drive(3, 4, 0, 0, 0, 0, 0);
        #1;
        for (int p = 0; p < 4; p++) check("wide_stored", w_rd[p*64 +: 64], 64'hFF00_0000_0000_00FF);
        cyc("pre_reset", 32'hFF, exp_rd(4), 0, 1, 1);

        #2;
        reset_n = 1'b0;
        #1;
        q.push_back('{"async_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0});
        pop_cmp();
        for (int p = 0; p < 4; p++) check("wide_reset", w_rd[p*64 +: 64], 64'd0);
        check("wide_any", {63'd0, w_any}, 64'd0);
        #3;
        reset_n = 1'b1;
        model_clear();
        @(posedge clk);
        #1;

        drive(3, 0, 1, 3, 32'h11, 0, 0);
        cyc("post_reset_wr", 32'h11, 0, 0, 0, 0);
        drive(3, 3, 0, 0, 0, 0, 0);
        cyc("post_reset_rd", 32'h11, 32'h11, 0, 0, 0);

        if (q.size() != 0) check("queue_left", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qm_regfile_sb.md
# qm_regfile_sb

Parametrised successor to the core's three-ported register file: NREAD combinational read ports, one clock-edge write port, write-through bypass, and a per-register load-pending scoreboard. Register 0 is hardwired to zero. It sits in the decode stage: decode reads operands and checks pending flags, writeback drives the write port, and the load unit marks destinations pending at issue. Clocked writes and an async-reset array replace the old level-sensitive write.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH
- NREAD, 2, number of read ports (1..4)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- ra  in  NREAD*ADDR_WIDTH  packed read addresses; port i = ra[i*ADDR_WIDTH +: ADDR_WIDTH]
- rd  out  NREAD*DATA_WIDTH  packed read data, same packing
- rd_pending  out  NREAD  per-port flag: addressed register has an outstanding load
- we  in  1  write enable
- wa  in  ADDR_WIDTH  write address
- wd  in  DATA_WIDTH  write data
- pend_set  in  1  mark register pend_addr pending (load issued)
- pend_addr  in  ADDR_WIDTH  destination of issued load
- any_pending  out  1  OR of all pending bits

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops plus 2**ADDR_WIDTH pending bits.
- Reset (reset_n low, asynchronous): all registers 0, all pending bits 0; held while low.
- Write: at posedge with we=1 and wa!=0, rf[wa] <= wd. Writes to address 0 discarded.
- Read port i, combinational, priority:
  - ra_i==0 -> rd_i = 0 (even if we with wa=0).
  - we=1 and wa==ra_i -> rd_i = wd (bypass, same cycle).
  - else rd_i = rf[ra_i].
- Scoreboard, per register r, next state at posedge:
  - pend_set=1, pend_addr==r, r!=0 -> 1 (set wins over simultaneous write to r).
  - else we=1, wa==r -> 0.
  - else hold.
  - pend_set to address 0 ignored; pending[0] always 0.
- rd_pending_i = pending[ra_i] and not (we=1 and wa==ra_i and not clear-overridden); i.e. a write arriving this cycle to a pending register deasserts rd_pending combinationally, because the bypassed data is valid. ra_i==0 -> 0.
- any_pending = OR of pending bits (registered state only; no bypass term).
- All read ports are independent; identical addresses on several ports return identical data.

## Timing
- Read latency: 0 cycles (combinational from ra, we, wa, wd and state).
- Write latency: visible through bypass in the write cycle, from the array from the next cycle.
- Pending: set visible on rd_pending one cycle after pend_set; clear visible combinationally in the write cycle and in state from the next cycle.
- Simultaneous pend_set and we to same r: data written, pending ends 1 (new load supersedes).
- Simultaneous pend_set to r and we to s!=r: both take effect.
- Reset asserted mid-operation: state clears immediately, without waiting for clk; rd outputs then read 0 (bypass still combinational on wd if we=1 and wa!=0 — decode must gate). First post-reset edge behaves as normal.
- Reset values: rd = 0 (absent bypass), rd_pending = 0, any_pending = 0.

## Test plan
- Reset then read all addresses on every port -> rd=0, rd_pending=0, any_pending=0.
- Write r5=0xDEADBEEF with ra0=5 in same cycle -> rd0=0xDEADBEEF via bypass; next cycle with we=0 -> still 0xDEADBEEF.
- Write r0=0x12345678, read ra0=0 during and after -> rd0=0 both cycles; pend_set to 0 -> any_pending stays 0.
- pend_set r7; next cycle ra1=7 -> rd_pending1=1, any_pending=1; write r7=0xA5 -> rd_pending1=0 and rd1=0xA5 same cycle; next cycle any_pending=0.
- Same-edge pend_set r9 and we r9=0x55 -> next cycle rf[9]=0x55, rd_pending for r9 =1.
- Write r3=0xFF, drop reset_n between edges -> rd for r3 reads 0 immediately, pending bits cleared; repeat with NREAD=4, DATA_WIDTH=64 build.
